// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction and data sides share one port.
// Ties alternate between the sides; every transaction ends with an idle cycle.
module mem_arbiter #(
   parameter int A_WIDTH = 32
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic [A_WIDTH-1:0] i_a,
   input  logic               i_strobe,
   output logic [31:0]        i_dout,
   output logic               i_ready,
   input  logic [A_WIDTH-1:0] d_a,
   input  logic               d_strobe,
   input  logic               d_write,
   input  logic [31:0]        d_wdata,
   output logic [31:0]        d_dout,
   output logic               d_ready,
   output logic [A_WIDTH-1:0] m_a,
   output logic               m_strobe,
   output logic               m_write,
   output logic [31:0]        m_din,
   input  logic [31:0]        m_dout,
   input  logic               m_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY_I,
      S_BUSY_D
   } state_e;

   localparam logic LG_I = 1'b0;
   localparam logic LG_D = 1'b1;

   state_e             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic [A_WIDTH-1:0] m_a_q, m_a_d;
   logic               m_strobe_q, m_strobe_d;
   logic               m_write_q, m_write_d;
   logic [31:0]        m_din_q, m_din_d;
   logic               grant_i, grant_d;

   // On a tie, the side that was not served last wins.
   assign grant_d = d_strobe && (!i_strobe || last_grant_q == LG_I);
   assign grant_i = i_strobe && !grant_d;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      m_a_d        = m_a_q;
      m_write_d    = m_write_q;
      m_din_d      = m_din_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant_d) begin
               state_d   = S_BUSY_D;
               m_a_d     = d_a;
               m_write_d = d_write;
               m_din_d   = d_wdata;
            end else if (grant_i) begin
               state_d   = S_BUSY_I;
               m_a_d     = i_a;
               m_write_d = 1'b0;
               m_din_d   = 32'h0;
            end
         end
         S_BUSY_I: begin
            if (m_ready) begin
               state_d      = S_IDLE;
               last_grant_d = LG_I;
            end
         end
         S_BUSY_D: begin
            if (m_ready) begin
               state_d      = S_IDLE;
               last_grant_d = LG_D;
            end
         end
         default: state_d = S_IDLE;
      endcase
      m_strobe_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= S_IDLE;
         last_grant_q <= LG_I;
         m_a_q        <= '0;
         m_strobe_q   <= 1'b0;
         m_write_q    <= 1'b0;
         m_din_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         m_a_q        <= m_a_d;
         m_strobe_q   <= m_strobe_d;
         m_write_q    <= m_write_d;
         m_din_q      <= m_din_d;
      end
   end

   assign m_a      = m_a_q;
   assign m_strobe = m_strobe_q;
   assign m_write  = m_write_q;
   assign m_din    = m_din_q;

   assign i_dout  = m_dout;
   assign d_dout  = m_dout;
   assign i_ready = (state_q == S_BUSY_I) && m_ready;
   assign d_ready = (state_q == S_BUSY_D) && m_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        clrn;
   logic [31:0] i_a;
   logic        i_strobe;
   logic [31:0] i_dout;
   logic        i_ready;
   logic [31:0] d_a;
   logic        d_strobe;
   logic        d_write;
   logic [31:0] d_wdata;
   logic [31:0] d_dout;
   logic        d_ready;
   logic [31:0] m_a;
   logic        m_strobe;
   logic        m_write;
   logic [31:0] m_din;
   logic [31:0] m_dout;
   logic        m_ready;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.A_WIDTH(32)) dut (
      .clk      (clk),
      .clrn     (clrn),
      .i_a      (i_a),
      .i_strobe (i_strobe),
      .i_dout   (i_dout),
      .i_ready  (i_ready),
      .d_a      (d_a),
      .d_strobe (d_strobe),
      .d_write  (d_write),
      .d_wdata  (d_wdata),
      .d_dout   (d_dout),
      .d_ready  (d_ready),
      .m_a      (m_a),
      .m_strobe (m_strobe),
      .m_write  (m_write),
      .m_din    (m_din),
      .m_dout   (m_dout),
      .m_ready  (m_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clrn     = 1'b0;
      i_a      = 32'h0;
      i_strobe = 1'b0;
      d_a      = 32'h0;
      d_strobe = 1'b0;
      d_write  = 1'b0;
      d_wdata  = 32'h0;
      m_dout   = 32'h0;
      m_ready  = 1'b0;
      #1;
      check("rst_strobe", {31'h0, m_strobe}, 32'h0);
      check("rst_m_a", m_a, 32'h0);
      check("rst_write", {31'h0, m_write}, 32'h0);
      check("rst_din", m_din, 32'h0);
      check("rst_readies", {30'h0, i_ready, d_ready}, 32'h0);
      tick();
      clrn = 1'b1;

      // single instruction read, memory answers on the third cycle
      i_strobe = 1'b1;
      i_a      = 32'hBFC00000;
      tick();
      check("i_strobe_up", {31'h0, m_strobe}, 32'h1);
      check("i_m_a", m_a, 32'hBFC00000);
      check("i_m_write", {31'h0, m_write}, 32'h0);
      tick();
      tick();
      check("i_wait_noready", {30'h0, i_ready, d_ready}, 32'h0);
      m_ready = 1'b1;
      m_dout  = 32'h3C1D0001;
      #1;
      check("i_ready", {31'h0, i_ready}, 32'h1);
      check("i_dout", i_dout, 32'h3C1D0001);
      check("i_d_ready0", {31'h0, d_ready}, 32'h0);
      tick();
      m_ready  = 1'b0;
      i_strobe = 1'b0;
      #1;
      check("i_done_strobe", {31'h0, m_strobe}, 32'h0);
      check("i_done_ready", {31'h0, i_ready}, 32'h0);

      // tie after reset: data first, address frozen while busy
      #1 clrn = 1'b0;
      #1 clrn = 1'b1;
      i_strobe = 1'b1;
      i_a      = 32'hBFC00004;
      d_strobe = 1'b1;
      d_a      = 32'h80001000;
      d_write  = 1'b1;
      d_wdata  = 32'hDEADBEEF;
      tick();
      check("tie_m_a", m_a, 32'h80001000);
      check("tie_m_write", {31'h0, m_write}, 32'h1);
      check("tie_m_din", m_din, 32'hDEADBEEF);
      check("tie_strobe", {31'h0, m_strobe}, 32'h1);
      d_a = 32'h80002000;
      tick();
      check("hold_m_a", m_a, 32'h80001000);
      m_ready = 1'b1;
      m_dout  = 32'h12345678;
      #1;
      check("tie_readies", {30'h0, i_ready, d_ready}, 32'h1);
      check("tie_d_dout", d_dout, 32'h12345678);
      check("hold_m_a_end", m_a, 32'h80001000);
      tick();
      m_ready  = 1'b0;
      d_strobe = 1'b0;
      #1;
      check("gap_strobe", {31'h0, m_strobe}, 32'h0);
      tick();
      check("i_after_d_strobe", {31'h0, m_strobe}, 32'h1);
      check("i_after_d_m_a", m_a, 32'hBFC00004);
      check("i_after_d_write", {31'h0, m_write}, 32'h0);
      check("i_after_d_din", m_din, 32'h0);
      m_ready = 1'b1;
      #1;
      check("i_after_d_ready", {30'h0, i_ready, d_ready}, 32'h2);
      tick();
      m_ready = 1'b0;

      // continuous contention: D, I, D, I
      d_strobe = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("alt_m_a", m_a, (k % 2 == 0) ? 32'h80002000 : 32'hBFC00004);
         check("alt_write", {31'h0, m_write}, (k % 2 == 0) ? 32'h1 : 32'h0);
         m_ready = 1'b1;
         #1;
         check("alt_ready", {30'h0, i_ready, d_ready},
               (k % 2 == 0) ? 32'h1 : 32'h2);
         tick();
         m_ready = 1'b0;
         #1;
         check("alt_idle", {31'h0, m_strobe}, 32'h0);
      end
      i_strobe = 1'b0;
      d_strobe = 1'b0;

      // data side drops its strobe mid-transaction; leaves last_grant = D
      tick();
      d_strobe = 1'b1;
      d_write  = 1'b0;
      tick();
      d_strobe = 1'b0;
      check("drop_strobe", {31'h0, m_strobe}, 32'h1);
      tick();
      m_ready = 1'b1;
      #1;
      check("drop_ready", {31'h0, d_ready}, 32'h1);
      tick();
      m_ready = 1'b0;

      // reset aborts a busy instruction fetch
      i_strobe = 1'b1;
      tick();
      check("abort_busy", {31'h0, m_strobe}, 32'h1);
      i_strobe = 1'b0;
      tick();
      clrn    = 1'b0;
      m_ready = 1'b1;
      #1;
      check("abort_strobe", {31'h0, m_strobe}, 32'h0);
      check("abort_ready", {30'h0, i_ready, d_ready}, 32'h0);
      check("abort_m_a", m_a, 32'h0);
      #2;
      m_ready  = 1'b0;
      clrn     = 1'b1;
      i_strobe = 1'b1;
      d_strobe = 1'b1;
      d_write  = 1'b1;
      tick();
      check("post_rst_grant", {31'h0, m_strobe}, 32'h1);
      check("post_rst_tie_d", m_a, 32'h80002000);
      m_ready = 1'b1;
      #1;
      check("post_rst_ready", {30'h0, i_ready, d_ready}, 32'h1);
      tick();
      m_ready  = 1'b0;
      i_strobe = 1'b0;
      d_strobe = 1'b0;
      tick();

      // stray m_ready while idle
      m_ready = 1'b1;
      #1;
      check("idle_mready", {30'h0, i_ready, d_ready}, 32'h0);
      tick();
      check("idle_state", {31'h0, m_strobe}, 32'h0);
      m_ready = 1'b0;
      tick();
      check("idle_stays", {31'h0, m_strobe}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter A_WIDTH, default 32, width of all address ports.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 i_a  input  A_WIDTH  instruction-side miss address.
REQ-005 i_strobe  input  1  instruction-side request, held until i_ready.
REQ-006 i_dout  output  32  instruction-side read data.
REQ-007 i_ready  output  1  instruction-side completion pulse.
REQ-008 d_a  input  A_WIDTH  data-side address.
REQ-009 d_strobe  input  1  data-side request, held until d_ready.
REQ-010 d_write  input  1  data-side write enable (1 = write, 0 = read).
REQ-011 d_wdata  input  32  data-side write data.
REQ-012 d_dout  output  32  data-side read data.
REQ-013 d_ready  output  1  data-side completion pulse.
REQ-014 m_a  output  A_WIDTH  memory address.
REQ-015 m_strobe  output  1  memory request.
REQ-016 m_write  output  1  memory write enable.
REQ-017 m_din  output  32  memory write data.
REQ-018 m_dout  input  32  memory read data.
REQ-019 m_ready  input  1  memory completion, one-cycle pulse.

Function
REQ-020 FSM states SHALL be IDLE, BUSY_I, BUSY_D.
REQ-021 IDLE transitions: i_strobe only -> BUSY_I; d_strobe only -> BUSY_D; neither -> stay.
REQ-022 When both strobes are high in IDLE, the block SHALL grant the side not granted last, using a 1-bit last_grant register.
REQ-023 On any grant, the block SHALL register the granted side's address into m_a.
REQ-024 On a data-side grant, the block SHALL also register d_write into m_write and d_wdata into m_din.
REQ-025 On an instruction-side grant, the block SHALL set m_write to 0 and m_din to 0.
REQ-026 m_strobe SHALL be registered and high exactly while the state is BUSY_I or BUSY_D.
REQ-027 Request timing: a request sampled in IDLE at edge N SHALL produce m_strobe high from cycle N+1.
REQ-028 m_a, m_write and m_din SHALL hold stable throughout BUSY_x, regardless of changes on the requester's inputs.
REQ-029 In BUSY_x with m_ready=1, x_ready SHALL be 1 combinationally in that same cycle.
REQ-030 On that completing edge, the FSM SHALL return to IDLE, m_strobe SHALL drop, and last_grant SHALL be set to x.
REQ-031 i_dout and d_dout SHALL both equal m_dout at all times; i_ready and d_ready qualify them.
REQ-032 The non-granted side's ready SHALL be 0; both readies SHALL be 0 in IDLE.
REQ-033 m_ready SHALL be ignored in IDLE.
REQ-034 Each transaction SHALL be followed by at least one IDLE cycle, so back-to-back grants are at least 2 cycles apart.
REQ-035 If the granted requester drops its strobe mid-transaction, the transaction SHALL still complete and x_ready SHALL still pulse.
REQ-036 The requester's strobe SHALL be re-sampled only in IDLE.
REQ-037 A requester still holding its strobe after its ready pulse SHALL be treated as a new request.

Reset
REQ-038 With clrn=0, the block SHALL immediately force state to IDLE, m_strobe to 0, m_write to 0, m_a to 0, m_din to 0 and last_grant to I.
REQ-039 Because last_grant resets to I, the first tie after reset SHALL go to the data side.
REQ-040 Reset asserted during BUSY_x SHALL abort the transaction with no ready pulse.
REQ-041 After clrn deasserts, the first grant SHALL be possible at the first rising edge.

Verification
REQ-042 Single instruction read: i_strobe=1, i_a=0xBFC00000; memory answers m_ready after 3 cycles with m_dout=0x3C1D0001 -> m_a=0xBFC00000, m_write=0, i_ready pulses 1 cycle with i_dout=0x3C1D0001, d_ready stays 0.
REQ-043 Tie after reset: i_strobe and d_strobe rise together, d_a=0x80001000, d_write=1, d_wdata=0xDEADBEEF -> data served first with m_a=0x80001000, m_write=1, m_din=0xDEADBEEF; instruction granted 2 cycles after d_ready.
REQ-044 Continuous contention over 4 transactions with both strobes held -> grants alternate D, I, D, I.
REQ-045 d_a changed from 0x80001000 to 0x80002000 mid-BUSY_D -> m_a stays 0x80001000 until m_ready.
REQ-046 clrn pulsed low during BUSY_I before m_ready -> m_strobe 0 immediately, no i_ready pulse, next tie grants the data side.
REQ-047 m_ready pulsed in IDLE with no request -> no ready output and no state change.
